// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: PC geometry, reset vector and the
// enums that make the next-PC generator's state and chosen source visible.
package cpu_pkg;

    localparam int PC_WIDTH = 16;
    localparam int PC_STEP  = 4;
    localparam logic [PC_WIDTH-1:0] PC_RESET_VEC = 16'h0000;

    typedef enum logic {
        RUN,
        HALTED
    } pc_state_t;

    typedef enum logic [2:0] {
        SRC_HOLD,
        SRC_RET,
        SRC_CALL,
        SRC_JUMP,
        SRC_BRANCH,
        SRC_SEQ
    } pc_src_t;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push while full silently overwrites the
// oldest entry; replace rewrites the top entry in place.
module ras_stack #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             replace,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] top_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;
    logic [CW-1:0]    cnt;

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign top_data = mem[ptr];

    // ptr always addresses the current top entry; a reset only clears the
    // bookkeeping, which is enough to discard every stored address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push) begin
            ptr <= ptr + PTR_ONE;
            if (!full) cnt <= cnt + CNT_ONE;
        end else if (pop) begin
            ptr <= ptr - PTR_ONE;
            cnt <= cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push)         mem[ptr + PTR_ONE] <= wdata;
        else if (replace) mem[ptr]           <= wdata;
    end

endmodule

// File: rtl/pc_next_gen.sv
// Next-fetch-address generator feeding p_counter: prioritised PC source mux,
// run/halted FSM, return-address stack and sticky stack error flags.
module pc_next_gen
    import cpu_pkg::*;
#(
    parameter  int                 WIDTH     = PC_WIDTH,
    parameter  int                 STEP      = PC_STEP,
    parameter  int                 RAS_DEPTH = 4,
    parameter  logic [WIDTH-1:0]   RESET_VEC = PC_RESET_VEC,
    localparam int                 CW        = $clog2(RAS_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] PC,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             call,
    input  logic             ret,
    input  logic             halt,
    output logic [WIDTH-1:0] PC_Next,
    output logic             halted,
    output logic             ras_ovf,
    output logic             ras_unf,
    output pc_state_t        dbg_state,
    output pc_src_t          dbg_src,
    output logic [CW-1:0]    dbg_ras_count
);

    function automatic logic [WIDTH-1:0] align(input logic [WIDTH-1:0] a);
        return {a[WIDTH-1:2], 2'b00};
    endfunction

    pc_state_t        state, state_nxt;
    pc_src_t          src;
    logic [WIDTH-1:0] seq, nxt;
    logic [WIDTH-1:0] ras_top;
    logic             ras_full, ras_empty;
    logic             push, pop, replace, set_ovf, set_unf;

    assign seq = PC + WIDTH'(STEP);

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .replace  (replace),
        .wdata    (seq),
        .top_data (ras_top),
        .count    (dbg_ras_count),
        .full     (ras_full),
        .empty    (ras_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == RUN && halt) state_nxt = HALTED;
    end

    always_comb begin
        halted    = (state == HALTED);
        dbg_state = state;
    end

    // Source selection; a simultaneous call+ret turns into a top-of-stack
    // replace (or a single push when the stack was already empty).
    always_comb begin
        src     = SRC_SEQ;
        nxt     = seq;
        push    = 1'b0;
        pop     = 1'b0;
        replace = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (state == HALTED || halt || stall) begin
            src = SRC_HOLD;
            nxt = PC;
        end else if (ret) begin
            src = SRC_RET;
            if (!ras_empty) begin
                nxt     = ras_top;
                replace = call;
                pop     = !call;
            end else begin
                nxt     = seq;
                set_unf = 1'b1;
                push    = call;
            end
        end else if (call) begin
            src     = SRC_CALL;
            nxt     = align(jump_target);
            push    = 1'b1;
            set_ovf = ras_full;
        end else if (jump) begin
            src = SRC_JUMP;
            nxt = align(jump_target);
        end else if (branch_taken) begin
            src = SRC_BRANCH;
            nxt = align(branch_target);
        end
    end

    assign PC_Next = rst ? nxt : RESET_VEC;
    assign dbg_src = src;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
        end else begin
            if (set_ovf) ras_ovf <= 1'b1;
            if (set_unf) ras_unf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_next_gen.sv
// Bench for pc_next_gen: the bench plays p_counter, driving PC directly, and
// checks against a queue-based model of the stack and flags.
module tb_pc_next_gen;
    import cpu_pkg::*;

    localparam int W = 16;
    localparam int D = 4;

    logic         clk, rst;
    logic [W-1:0] PC, branch_target, jump_target;
    logic         stall, branch_taken, jump, call, ret, halt;
    logic [W-1:0] PC_Next;
    logic         halted, ras_ovf, ras_unf;
    pc_state_t    dbg_state;
    pc_src_t      dbg_src;
    logic [2:0]   dbg_ras_count;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [W-1:0] m_ras[$];
    logic         m_halted, m_ovf, m_unf;
    logic [W-1:0] last_exp;

    pc_next_gen #(.WIDTH(W), .STEP(4), .RAS_DEPTH(D), .RESET_VEC(16'h0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .PC            (PC),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .call          (call),
        .ret           (ret),
        .halt          (halt),
        .PC_Next       (PC_Next),
        .halted        (halted),
        .ras_ovf       (ras_ovf),
        .ras_unf       (ras_unf),
        .dbg_state     (dbg_state),
        .dbg_src       (dbg_src),
        .dbg_ras_count (dbg_ras_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model_next();
        logic [W-1:0] s;
        s = PC + 16'd4;
        if (m_halted || halt || stall) return PC;
        if (ret) return (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : s;
        if (call || jump) return jump_target & 16'hFFFC;
        if (branch_taken) return branch_target & 16'hFFFC;
        return s;
    endfunction

    task automatic model_commit();
        logic [W-1:0] s;
        s = PC + 16'd4;
        if (m_halted || halt) begin
            m_halted = 1'b1;
            return;
        end
        if (stall) return;
        if (ret) begin
            if (m_ras.size() > 0) begin
                if (call) m_ras[m_ras.size()-1] = s;
                else      void'(m_ras.pop_back());
            end else begin
                m_unf = 1'b1;
                if (call) m_ras.push_back(s);
            end
        end else if (call) begin
            if (m_ras.size() == D) begin
                m_ovf = 1'b1;
                void'(m_ras.pop_front());
            end
            m_ras.push_back(s);
        end
    endtask

    task automatic drive(input logic [W-1:0] p, input logic s, input logic b, input logic [W-1:0] bt,
                         input logic j, input logic [W-1:0] jt, input logic c, input logic r, input logic h);
        PC = p; stall = s; branch_taken = b; branch_target = bt;
        jump = j; jump_target = jt; call = c; ret = r; halt = h;
    endtask

    task automatic settle_check(input string tag);
        logic [W-1:0] e;
        #2;
        e = model_next();
        last_exp = e;
        check({tag, ":pc_next"}, 32'(PC_Next), 32'(e));
        check({tag, ":halted"},  32'(halted),  32'(m_halted));
        check({tag, ":ras_ovf"}, 32'(ras_ovf), 32'(m_ovf));
        check({tag, ":ras_unf"}, 32'(ras_unf), 32'(m_unf));
        check({tag, ":count"},   32'(dbg_ras_count), 32'(m_ras.size()));
    endtask

    task automatic commit();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    // one full cycle; when chk is set, PC_Next is also held to a fixed constant
    task automatic cyc(input logic [W-1:0] p, input logic s, input logic b, input logic [W-1:0] bt,
                       input logic j, input logic [W-1:0] jt, input logic c, input logic r, input logic h,
                       input logic chk, input logic [W-1:0] exp, input string tag);
        drive(p, s, b, bt, j, jt, c, r, h);
        settle_check(tag);
        if (chk) check({tag, ":const"}, 32'(PC_Next), 32'(exp));
        commit();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        PC  = 16'h1230;
        #1;
        check("rst:pc_next", 32'(PC_Next), 32'h0);
        check("rst:halted",  32'(halted),  32'h0);
        check("rst:ras_ovf", 32'(ras_ovf), 32'h0);
        check("rst:ras_unf", 32'(ras_unf), 32'h0);
        check("rst:count",   32'(dbg_ras_count), 32'h0);
        m_ras.delete();
        m_halted = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        logic [W-1:0] pc;
        logic         s, b;
        logic [W-1:0] bt;
        logic         j;
        logic [W-1:0] jt;
        logic         c, r, h;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [W-1:0] p;
        logic [W-1:0] v;

        vecs[0] = '{16'h0010, 1'b0, 1'b1, 16'h0041, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0040};
        vecs[1] = '{16'h0010, 1'b0, 1'b1, 16'h0041, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 16'h0100};
        vecs[2] = '{16'hFFFC, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[3] = '{16'h0010, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0103, 1'b0, 1'b0, 1'b0, 16'h0100};
        vecs[4] = '{16'h0008, 1'b1, 1'b1, 16'h0080, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0008};
        vecs[5] = '{16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h1238};
        vecs[6] = '{16'h0040, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0200, 1'b1, 1'b0, 1'b0, 16'h0040};
        vecs[7] = '{16'h0050, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0054};

        drive(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        do_reset();

        // sequential run with PC fed back, then async reset with a live stack entry
        p = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            v = p + 16'd4;
            cyc(p, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, v, "seq_run");
            p = last_exp;
        end
        cyc(p, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0400, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0400, "pre_rst_call");
        #2;
        do_reset();
        check("post_rst_empty", 32'(dbg_ras_count), 32'h0);
        cyc(16'h0400, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0404, "post_rst_ret");
        do_reset();

        // table of single-cycle source-priority vectors
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].pc, vecs[i].s, vecs[i].b, vecs[i].bt, vecs[i].j, vecs[i].jt,
                  vecs[i].c, vecs[i].r, vecs[i].h);
            settle_check($sformatf("vec%0d", i));
            check($sformatf("vec%0d:table", i), 32'(PC_Next), 32'(vecs[i].exp));
            commit();
        end
        check("vec_unf_sticky", 32'(ras_unf), 32'h1);
        do_reset();

        // nested call/ret and underflow
        cyc(16'h0020, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0200, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0200, "call1");
        cyc(16'h0204, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0300, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0300, "call2");
        cyc(16'h0300, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0,    1'b0, 1'b1, 1'b0, 1'b1, 16'h0208, "ret1");
        cyc(16'h0208, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0,    1'b0, 1'b1, 1'b0, 1'b1, 16'h0024, "ret2");
        cyc(16'h0024, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0,    1'b0, 1'b1, 1'b0, 1'b1, 16'h0028, "ret3");
        #2;
        check("ret3_unf", 32'(ras_unf), 32'h1);
        check("ret3_no_ovf", 32'(ras_ovf), 32'h0);
        do_reset();

        // overflow: five calls into a four-deep stack
        for (int i = 1; i <= 5; i++) begin
            v = 16'(i * 256 + 256);
            cyc(16'(i * 256), 1'b0, 1'b0, 16'h0, 1'b0, v, 1'b1, 1'b0, 1'b0, 1'b1, v, "ovf_call");
        end
        #2;
        check("ovf_set", 32'(ras_ovf), 32'h1);
        for (int i = 5; i >= 2; i--) begin
            v = 16'(i * 256 + 4);
            cyc(16'h0600, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1, v, "ovf_ret");
        end
        cyc(16'h0600, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0604, "ovf_ret5");
        #2;
        check("ovf_ret5_unf", 32'(ras_unf), 32'h1);
        do_reset();

        // call+ret in one cycle, empty and non-empty
        cyc(16'h0040, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0100, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0044, "cr_empty");
        #2;
        check("cr_empty_cnt", 32'(dbg_ras_count), 32'h1);
        check("cr_empty_unf", 32'(ras_unf), 32'h1);
        cyc(16'h0100, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0200, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0200, "cr_call");
        cyc(16'h0200, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0300, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0104, "cr_full");
        #2;
        check("cr_full_cnt", 32'(dbg_ras_count), 32'h2);
        cyc(16'h0104, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0204, "cr_ret1");
        cyc(16'h0204, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0044, "cr_ret2");
        do_reset();

        // halt is sticky and masks every control input
        cyc(16'h0010, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0500, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0500, "halt_pre");
        cyc(16'h0030, 1'b0, 1'b1, 16'h0080, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0030, "halt_cyc");
        #2;
        check("halted_next", 32'(halted), 32'h1);
        cyc(16'h0030, 1'b0, 1'b1, 16'h0080, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0030, "halt_br");
        cyc(16'h0030, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0700, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0030, "halt_call");
        cyc(16'h0030, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0030, "halt_ret");
        #2;
        check("halt_cnt_kept", 32'(dbg_ras_count), 32'h1);
        do_reset();

        // randomized traffic against the model
        last_exp = 16'h0000;
        for (int i = 0; i < 400; i++) begin
            if (m_halted && $urandom_range(0, 3) == 0) do_reset();
            if ($urandom_range(0, 1) == 0) p = last_exp;
            else                           p = 16'($urandom()) & 16'hFFFC;
            cyc(p,
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 3) == 0, 16'($urandom()),
                $urandom_range(0, 5) == 0, 16'($urandom()),
                $urandom_range(0, 4) == 0,
                $urandom_range(0, 4) == 0,
                $urandom_range(0, 99) == 0,
                1'b0, 16'h0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
